// File: rtl/poly_minmax_pkg.sv
// -----------------------------------------------------------------------------
// poly_minmax_pkg
// Shared definitions for the polynomial min/max scanner:
//   - default widths for argument/result data and the point counter
//   - default evaluator timeout
//   - FSM state encoding used by poly_minmax_scan
//   - helper to size the per-point wait timer
// -----------------------------------------------------------------------------
package poly_minmax_pkg;

  localparam int DW_DEF      = 32;  // argument / result width
  localparam int NW_DEF      = 16;  // point counter width
  localparam int TIMEOUT_DEF = 64;  // max WAIT cycles per point

  // Scan sequencer states. One point costs ISSUE + GAP + WAIT(n) + UPDATE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_GAP    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  // Width needed for a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/minmax_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
// Keeps the signed minimum and maximum of a stream of samples together with
// the argument that produced each extreme.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset (all state to 0)
//   clear    in   drop valid and zero the extremes (start of a new scan)
//   update   in   a new sample/arg pair is presented this cycle
//   first    in   with update: this is the first sample, load both extremes
//   sample   in   signed sample value
//   arg      in   argument associated with the sample
//   valid    out  at least one sample has been loaded since clear
//   min_val  out  smallest sample seen (signed)
//   max_val  out  largest sample seen (signed)
//   min_arg  out  argument of min_val
//   max_arg  out  argument of max_val
// -----------------------------------------------------------------------------
module minmax_tracker
  import poly_minmax_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          update,
  input  logic          first,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] arg,
  output logic          valid,
  output logic [DW-1:0] min_val,
  output logic [DW-1:0] max_val,
  output logic [DW-1:0] min_arg,
  output logic [DW-1:0] max_arg
);

  logic valid_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (update) begin
      valid_reg <= 1'b1;
    end
  end

  // Lane 0 tracks the minimum, lane 1 the maximum. Both use a strict
  // comparison so a later tie never displaces the earlier argument.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [DW-1:0] val_reg;
    logic [DW-1:0] arg_reg;
    logic          beats;

    if (gi == 0) begin : g_min
      assign beats = $signed(sample) < $signed(val_reg);
    end else begin : g_max
      assign beats = $signed(sample) > $signed(val_reg);
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        val_reg <= '0;
        arg_reg <= '0;
      end else if (clear) begin
        val_reg <= '0;
        arg_reg <= '0;
      end else if (update && (first || beats)) begin
        val_reg <= sample;
        arg_reg <= arg;
      end
    end
  end

  assign valid   = valid_reg;
  assign min_val = g_lane[0].val_reg;
  assign min_arg = g_lane[0].arg_reg;
  assign max_val = g_lane[1].val_reg;
  assign max_arg = g_lane[1].arg_reg;

endmodule

// File: rtl/poly_minmax_scan.sv
// -----------------------------------------------------------------------------
// poly_minmax_scan
// Sweeps an argument x over n_points evenly stepped values, issuing one
// start/ready transaction per point to a polynomial evaluator, and tracks the
// signed minimum and maximum results with the arguments that produced them.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   start_in       in   1-cycle scan request, only honoured in IDLE
//   x_start        in   first argument (signed), sampled on accepted start
//   x_step         in   argument increment (signed), sampled on accepted start
//   n_points       in   number of points, sampled on accepted start
//   horner_start   out  1-cycle start pulse to the evaluator
//   horner_arg     out  argument to the evaluator, held until result taken
//   horner_ready   in   evaluator result-valid level
//   horner_result  in   evaluator result (signed)
//   busy           out  scan in progress
//   done           out  1-cycle pulse at the end of every scan
//   valid          out  min/max outputs hold at least one sample
//   err            out  evaluator timeout, sticky until next accepted start
//   min_val        out  smallest result (signed)
//   max_val        out  largest result (signed)
//   min_arg        out  argument that produced min_val
//   max_arg        out  argument that produced max_val
// -----------------------------------------------------------------------------
module poly_minmax_scan
  import poly_minmax_pkg::*;
#(
  parameter int DW             = DW_DEF,
  parameter int NW             = NW_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_in,
  input  logic [DW-1:0] x_start,
  input  logic [DW-1:0] x_step,
  input  logic [NW-1:0] n_points,
  output logic          horner_start,
  output logic [DW-1:0] horner_arg,
  input  logic          horner_ready,
  input  logic [DW-1:0] horner_result,
  output logic          busy,
  output logic          done,
  output logic          valid,
  output logic          err,
  output logic [DW-1:0] min_val,
  output logic [DW-1:0] max_val,
  output logic [DW-1:0] min_arg,
  output logic [DW-1:0] max_arg
);

  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_reg;
  state_t        state_next;

  logic [DW-1:0] x_reg;
  logic [DW-1:0] step_reg;
  logic [DW-1:0] result_reg;
  logic [NW-1:0] cnt_reg;
  logic [TW-1:0] timer_reg;
  logic          err_reg;

  logic          accept;
  logic          timeout_hit;
  logic          track_update;

  // A request only counts in IDLE; FINISH always returns to IDLE first, so a
  // start coinciding with done is dropped.
  assign accept      = (state_reg == ST_IDLE) && start_in;
  assign timeout_hit = (state_reg == ST_WAIT) && !horner_ready && (timer_reg == TIMER_LAST);
  assign track_update = (state_reg == ST_UPDATE);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_in) begin
          state_next = (n_points == '0) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE:  state_next = ST_GAP;
      // The evaluator may still show ready from the previous point here.
      ST_GAP:    state_next = ST_WAIT;
      ST_WAIT: begin
        if (horner_ready) begin
          state_next = ST_UPDATE;
        end else if (timeout_hit) begin
          state_next = ST_FINISH;
        end
      end
      // cnt_reg still holds the count including the point just finished.
      ST_UPDATE: state_next = (cnt_reg == NW'(1)) ? ST_FINISH : ST_ISSUE;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    horner_start = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_reg)
      ST_ISSUE: begin
        horner_start = 1'b1;
        busy         = 1'b1;
      end
      ST_GAP, ST_WAIT, ST_UPDATE: busy = 1'b1;
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: argument, point counter, wait timer, captured result, error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_reg      <= '0;
      step_reg   <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      timer_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            x_reg    <= x_start;
            step_reg <= x_step;
            cnt_reg  <= n_points;
            err_reg  <= 1'b0;
          end
        end
        ST_GAP: timer_reg <= '0;
        ST_WAIT: begin
          if (horner_ready) begin
            result_reg <= horner_result;
          end else if (timeout_hit) begin
            err_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ST_UPDATE: begin
          // Two's-complement wrap is intended: no saturation on the sweep.
          x_reg   <= x_reg + step_reg;
          cnt_reg <= cnt_reg - NW'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Extreme tracking. The argument passed alongside the sample is x_reg, which
  // is still the value that was sent to the evaluator for this point.
  // ---------------------------------------------------------------------------
  minmax_tracker #(
    .DW(DW)
  ) u_tracker (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .update  (track_update),
    .first   (!valid),
    .sample  (result_reg),
    .arg     (x_reg),
    .valid   (valid),
    .min_val (min_val),
    .max_val (max_val),
    .min_arg (min_arg),
    .max_arg (max_arg)
  );

  assign horner_arg = x_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_poly_minmax_scan.sv
// -----------------------------------------------------------------------------
// tb_poly_minmax_scan
// Directed bench for poly_minmax_scan with a behavioural degree-5 evaluator
// stand-in. Expected evaluator arguments are queued when a scan is launched
// and checked at each start pulse; end-of-scan results are checked on done.
// -----------------------------------------------------------------------------
module tb_poly_minmax_scan;

  localparam int DW = 32;
  localparam int NW = 16;
  localparam int TO = 16;

  logic          clock;
  logic          reset;
  logic          start_in;
  logic [DW-1:0] x_start;
  logic [DW-1:0] x_step;
  logic [NW-1:0] n_points;
  logic          horner_start;
  logic [DW-1:0] horner_arg;
  logic          horner_ready;
  logic [DW-1:0] horner_result;
  logic          busy;
  logic          done;
  logic          valid;
  logic          err;
  logic [DW-1:0] min_val;
  logic [DW-1:0] max_val;
  logic [DW-1:0] min_arg;
  logic [DW-1:0] max_arg;

  poly_minmax_scan #(
    .DW(DW),
    .NW(NW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_in      (start_in),
    .x_start       (x_start),
    .x_step        (x_step),
    .n_points      (n_points),
    .horner_start  (horner_start),
    .horner_arg    (horner_arg),
    .horner_ready  (horner_ready),
    .horner_result (horner_result),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .err           (err),
    .min_val       (min_val),
    .max_val       (max_val),
    .min_arg       (min_arg),
    .max_arg       (max_arg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Evaluator stand-in: CN0 is the x^5 coefficient, CN5 the constant term.
  // It notices start one cycle late, so the previous ready level is still
  // visible during the scanner's guard cycle.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] cn [6];
  int            eval_lat;
  logic          stub_dead;
  logic          start_seen;
  logic          pend;
  int            lat;
  logic [DW-1:0] arg_lat;

  function automatic logic [DW-1:0] poly(input logic [DW-1:0] x);
    logic [DW-1:0] acc;
    acc = cn[0];
    for (int k = 1; k < 6; k++) acc = acc * x + cn[k];
    return acc;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      horner_ready  <= 1'b0;
      horner_result <= '0;
      start_seen    <= 1'b0;
      pend          <= 1'b0;
      lat           <= 0;
      arg_lat       <= '0;
    end else begin
      start_seen <= horner_start;
      if (start_seen) begin
        horner_ready <= 1'b0;
        pend         <= 1'b1;
        lat          <= 0;
        arg_lat      <= horner_arg;
      end else if (pend) begin
        if (lat >= eval_lat - 1) begin
          pend <= 1'b0;
          if (!stub_dead) begin
            horner_ready  <= 1'b1;
            horner_result <= poly(arg_lat);
          end
        end else begin
          lat <= lat + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and checking
  // ---------------------------------------------------------------------------
  logic [DW-1:0] arg_q [$];
  int            tests;
  int            fails;
  int            pulse_cnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Every wait in the bench goes through here so start pulses are always seen.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clock);
    if (reset === 1'b1 && horner_start === 1'b1) begin
      pulse_cnt++;
      tests++;
      assert (arg_q.size() != 0)
      else begin
        fails++;
        $error("FAIL unexpected_pulse: observed pulse with arg %h expected none", horner_arg);
      end
      if (arg_q.size() != 0) begin
        e = arg_q.pop_front();
        $display("[TB] horner_start arg=%h expected=%h", horner_arg, e);
        chk("horner_arg", horner_arg, e);
      end
    end
  endtask

  task automatic push_args(input logic [DW-1:0] x0, input logic [DW-1:0] st, input int n);
    logic [DW-1:0] x;
    x = x0;
    for (int i = 0; i < n; i++) begin
      arg_q.push_back(x);
      x = x + st;
    end
  endtask

  task automatic drive_start(input logic [DW-1:0] x0, input logic [DW-1:0] st, input logic [NW-1:0] n);
    x_start  = x0;
    x_step   = st;
    n_points = n;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  // Called one negedge after the start was driven; returns cycles to done.
  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    tests++;
    assert (done === 1'b1)
    else begin
      fails++;
      $error("FAIL %s_done_timeout: observed done=%b after %0d cycles expected 1", tag, done, cycles);
    end
    $display("[TB] %s done after %0d cycles", tag, cycles);
  endtask

  task automatic check_end(input string tag, input logic chk_vals,
                           input logic [DW-1:0] e_min, input logic [DW-1:0] e_max,
                           input logic [DW-1:0] e_mina, input logic [DW-1:0] e_maxa,
                           input logic e_valid, input logic e_err,
                           input int e_pulses, input int p0);
    chk({tag, "_valid"}, DW'(valid), DW'(e_valid));
    chk({tag, "_err"}, DW'(err), DW'(e_err));
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_pulses"}, DW'(pulse_cnt - p0), DW'(e_pulses));
    chk({tag, "_args_left"}, DW'(arg_q.size()), '0);
    if (chk_vals) begin
      chk({tag, "_min_val"}, min_val, e_min);
      chk({tag, "_max_val"}, max_val, e_max);
      chk({tag, "_min_arg"}, min_arg, e_mina);
      chk({tag, "_max_arg"}, max_arg, e_maxa);
    end
  endtask

  // After done: done must drop; optionally pulse start_in in the done cycle
  // and confirm it is not taken.
  task automatic after_done(input string tag, input logic poke);
    if (poke) begin
      x_start  = 32'd100;
      x_step   = 32'd1;
      n_points = 16'd3;
      start_in = 1'b1;
    end
    tick();
    start_in = 1'b0;
    chk({tag, "_done_width"}, DW'(done), '0);
    chk({tag, "_busy_after"}, DW'(busy), '0);
    tick();
    chk({tag, "_busy_after2"}, DW'(busy), '0);
    chk({tag, "_no_restart"}, DW'(horner_start), '0);
  endtask

  initial begin
    int cyc;
    int p0;
    tests     = 0;
    fails     = 0;
    pulse_cnt = 0;
    reset     = 1'b0;
    start_in  = 1'b0;
    x_start   = '0;
    x_step    = '0;
    n_points  = '0;
    eval_lat  = 4;
    stub_dead = 1'b0;
    for (int k = 0; k < 6; k++) cn[k] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", DW'(busy), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_hstart", DW'(horner_start), '0);
    chk("rst_valid", DW'(valid), '0);
    chk("rst_err", DW'(err), '0);
    chk("rst_harg", horner_arg, '0);
    chk("rst_min_val", min_val, '0);
    reset = 1'b1;
    tick();
    chk("rel_hstart", DW'(horner_start), '0);
    chk("rel_busy", DW'(busy), '0);

    // 1: constant 7, four points; also start_in in the done cycle is ignored
    cn[5] = 32'd7;
    p0 = pulse_cnt;
    push_args(32'd10, 32'd1, 4);
    drive_start(32'd10, 32'd1, 16'd4);
    wait_done("t1", 200, cyc);
    check_end("t1", 1'b1, 32'd7, 32'd7, 32'd10, 32'd10, 1'b1, 1'b0, 4, p0);
    after_done("t1", 1'b1);

    // 2: x^2 - 4 over -3..3; tie at +3 keeps -3 as max_arg
    cn[3] = 32'd1;
    cn[5] = 32'hFFFF_FFFC;
    p0 = pulse_cnt;
    push_args(32'hFFFF_FFFD, 32'd1, 7);
    drive_start(32'hFFFF_FFFD, 32'd1, 16'd7);
    wait_done("t2", 300, cyc);
    check_end("t2", 1'b1, 32'hFFFF_FFFC, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 1'b0, 7, p0);
    after_done("t2", 1'b0);

    // 3: empty scan
    p0 = pulse_cnt;
    drive_start(32'd5, 32'd1, 16'd0);
    wait_done("t3", 10, cyc);
    chk("t3_latency", DW'(cyc), 32'd1);
    check_end("t3", 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 0, p0);
    after_done("t3", 1'b0);

    // 4: evaluator never answers -> timeout
    stub_dead = 1'b1;
    p0 = pulse_cnt;
    push_args(32'd1, 32'd1, 1);
    drive_start(32'd1, 32'd1, 16'd3);
    wait_done("t4", 60, cyc);
    tests++;
    assert (cyc >= 17 && cyc <= 19)
    else begin
      fails++;
      $error("FAIL t4_latency: observed %0d cycles expected 17..19", cyc);
    end
    check_end("t4", 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1, p0);
    after_done("t4", 1'b0);
    chk("t4_err_sticky", DW'(err), 32'd1);
    stub_dead = 1'b0;

    // 5: argument wrap 0x7FFFFFFF -> 0x80000000 with x + 3; mid-scan start ignored
    for (int k = 0; k < 6; k++) cn[k] = '0;
    cn[4] = 32'd1;
    cn[5] = 32'd3;
    p0 = pulse_cnt;
    push_args(32'h7FFF_FFFF, 32'd1, 2);
    drive_start(32'h7FFF_FFFF, 32'd1, 16'd2);
    tick();
    tick();
    x_start  = 32'd0;
    n_points = 16'd5;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_done("t5", 200, cyc);
    check_end("t5", 1'b1, 32'h8000_0002, 32'h8000_0003, 32'h7FFF_FFFF, 32'h8000_0000,
              1'b1, 1'b0, 2, p0);
    after_done("t5", 1'b0);

    // 6: reset during WAIT, then a fresh scan
    cn[3] = 32'd1;
    cn[4] = 32'd0;
    cn[5] = 32'hFFFF_FFFC;
    eval_lat = 12;
    push_args(32'hFFFF_FFFD, 32'd1, 1);
    drive_start(32'hFFFF_FFFD, 32'd1, 16'd7);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_busy_pre", DW'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", DW'(busy), '0);
    chk("t6_rst_done", DW'(done), '0);
    chk("t6_rst_hstart", DW'(horner_start), '0);
    chk("t6_rst_harg", horner_arg, '0);
    chk("t6_rst_valid", DW'(valid), '0);
    chk("t6_rst_err", DW'(err), '0);
    chk("t6_rst_min_val", min_val, '0);
    chk("t6_rst_max_val", max_val, '0);
    chk("t6_rst_min_arg", min_arg, '0);
    chk("t6_rst_max_arg", max_arg, '0);
    arg_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t6_rel_hstart", DW'(horner_start), '0);
    chk("t6_rel_busy", DW'(busy), '0);
    eval_lat = 4;
    p0 = pulse_cnt;
    push_args(32'hFFFF_FFFD, 32'd1, 7);
    drive_start(32'hFFFF_FFFD, 32'd1, 16'd7);
    wait_done("t6", 300, cyc);
    check_end("t6", 1'b1, 32'hFFFF_FFFC, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 1'b0, 7, p0);
    after_done("t6", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
